// File: rtl/lsu_if.sv
// Memory-side bus of the load/store unit: request strobe, word address,
// lane-replicated write data, byte enables, and the completion handshake.
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // The LSU issues requests and receives completions.
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  // The memory receives requests and returns completions.
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: accepts one core data access at a time, checks funct3 and
// alignment, runs a single word-wide memory transaction with an ack timeout,
// and reports a one-cycle completion (DONE) carrying status and load data.
module lsu #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic [1:0]  err,
  lsu_if.master       mem
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_e;

  localparam logic [7:0] TERM_CNT = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic [1:0]  err_q, err_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;

  // Loads: pick the addressed lane and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Byte enables for the access size at the given byte offset.
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Stores: replicate the low byte/halfword across every lane.
  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  logic illegal_s, misaligned_s;

  // Classify the incoming request: bad encoding first, then alignment.
  always_comb begin
    illegal_s    = 1'b0;
    misaligned_s = 1'b0;
    case (req_funct3)
      3'b000:          illegal_s = 1'b0;
      3'b001, 3'b010:  illegal_s = 1'b0;
      3'b100, 3'b101:  illegal_s = req_we;
      default:         illegal_s = 1'b1;
    endcase
    if (req_funct3[1:0] == 2'b01) begin
      misaligned_s = req_addr[0];
    end else if (req_funct3[1:0] == 2'b10) begin
      misaligned_s = |req_addr[1:0];
    end else begin
      misaligned_s = 1'b0;
    end
  end

  // Next-state and registered-output computation for the IDLE/WAIT/DONE FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    err_d         = 2'b00;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          if (illegal_s) begin
            err_d   = 2'b11;
            state_d = ST_DONE;
          end else if (misaligned_s) begin
            err_d   = 2'b01;
            state_d = ST_DONE;
          end else begin
            state_d     = ST_WAIT;
            cnt_d       = 8'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = lane_be(req_funct3[1:0], req_addr[1:0]);
            mem_wdata_d = req_we ? lane_wdata(req_funct3[1:0], req_wdata) : 32'h0000_0000;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // An ack on the terminal-count cycle still completes normally.
        if (mem.mem_ack || cnt_q == TERM_CNT) begin
          state_d     = ST_DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'h0000_0000;
          mem_wdata_d = 32'h0000_0000;
          mem_be_d    = 4'b0000;
          if (mem.mem_ack) begin
            if (!mem_we_q) begin
              rdata_d       = load_extend(funct3_q, off_q, mem.mem_rdata);
              rdata_valid_d = 1'b1;
            end else begin
              rdata_valid_d = 1'b0;
            end
          end else begin
            err_d = 2'b10;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      funct3_q      <= 3'b000;
      off_q         <= 2'b00;
      rdata_q       <= 32'h0000_0000;
      rdata_valid_q <= 1'b0;
      err_q         <= 2'b00;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'h0000_0000;
      mem_wdata_q   <= 32'h0000_0000;
      mem_be_q      <= 4'b0000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
    end
  end

  assign stall         = (state_q == ST_IDLE && req_valid) || (state_q == ST_WAIT);
  assign rdata         = rdata_q;
  assign rdata_valid   = rdata_valid_q;
  assign err           = err_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_be    = mem_be_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: each scenario walks the accept/WAIT/DONE cycles
// by hand and compares outputs against hand-computed values.
module tb_lsu;
  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic [1:0]  err;

  int n_cmp;
  int n_bad;

  lsu_if mif ();

  lsu #(.ACK_TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .err         (err),
    .mem         (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_mem_req", mif.mem_req, 0);
    chk("rst_mem_we", mif.mem_we, 0);
    chk("rst_mem_be", mif.mem_be, 0);
    chk("rst_mem_addr", mif.mem_addr, 0);
    chk("rst_mem_wdata", mif.mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_stall0", stall, 0);
    req_valid = 1'b1; #1;
    chk("rst_stall1", stall, 1);
    req_valid = 1'b0;
    tick();
    reset = 1'b0;

    // lb 0x63, ack in cycle 3, DONE in cycle 4
    tick();
    drive_req(1'b0, 3'b000, 32'h0000_0063, 32'h0); #1;
    chk("lb_c0_stall", stall, 1);
    chk("lb_c0_req", mif.mem_req, 0);
    tick();
    chk("lb_c1_req", mif.mem_req, 1);
    chk("lb_c1_addr", mif.mem_addr, 32'h60);
    chk("lb_c1_be", mif.mem_be, 4'b1000);
    chk("lb_c1_wdata", mif.mem_wdata, 0);
    tick();
    chk("lb_c2_req", mif.mem_req, 1);
    tick();
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h80FF_1234; #1;
    chk("lb_c3_rvalid", rdata_valid, 0);
    chk("lb_c3_stall", stall, 1);
    tick();
    mif.mem_ack = 1'b0; req_valid = 1'b0; #1;
    chk("lb_c4_rvalid", rdata_valid, 1);
    chk("lb_c4_rdata", rdata, 32'hFFFF_FF80);
    chk("lb_c4_err", err, 0);
    chk("lb_c4_stall", stall, 0);
    chk("lb_c4_req", mif.mem_req, 0);
    tick();
    chk("lb_c5_rvalid", rdata_valid, 0);
    chk("lb_c5_rdata_hold", rdata, 32'hFFFF_FF80);

    // ack while IDLE is ignored
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1111_1111;
    tick();
    mif.mem_ack = 1'b0; #1;
    chk("idle_ack_rvalid", rdata_valid, 0);
    chk("idle_ack_rdata", rdata, 32'hFFFF_FF80);
    chk("idle_ack_req", mif.mem_req, 0);

    // sh 0x66, zero-wait ack
    drive_req(1'b1, 3'b001, 32'h0000_0066, 32'hDEAD_BEEF);
    tick();
    mif.mem_ack = 1'b1; #1;
    chk("sh_c1_wdata", mif.mem_wdata, 32'hBEEF_BEEF);
    chk("sh_c1_be", mif.mem_be, 4'b1100);
    chk("sh_c1_we", mif.mem_we, 1);
    chk("sh_c1_addr", mif.mem_addr, 32'h64);
    tick();
    mif.mem_ack = 1'b0; req_valid = 1'b0; #1;
    chk("sh_c2_rvalid", rdata_valid, 0);
    chk("sh_c2_err", err, 0);
    chk("sh_c2_stall", stall, 0);
    chk("sh_c2_rdata", rdata, 32'hFFFF_FF80);

    // sb 0x61: byte replication and shifted enable
    tick();
    drive_req(1'b1, 3'b000, 32'h0000_0061, 32'h0000_00A5);
    tick();
    mif.mem_ack = 1'b1; #1;
    chk("sb_wdata", mif.mem_wdata, 32'hA5A5_A5A5);
    chk("sb_be", mif.mem_be, 4'b0010);
    tick();
    mif.mem_ack = 1'b0; req_valid = 1'b0;

    // lw 0x62: misaligned, no memory access
    tick();
    drive_req(1'b0, 3'b010, 32'h0000_0062, 32'h0);
    tick();
    req_valid = 1'b0; #1;
    chk("lw_mis_req", mif.mem_req, 0);
    chk("lw_mis_err", err, 2'b01);
    chk("lw_mis_stall", stall, 0);
    chk("lw_mis_rvalid", rdata_valid, 0);
    tick();
    chk("lw_mis_err_clr", err, 0);

    // store with funct3 101 at odd address: illegal outranks misaligned
    drive_req(1'b1, 3'b101, 32'h0000_0061, 32'h0);
    tick();
    req_valid = 1'b0; #1;
    chk("st_ill_err", err, 2'b11);
    chk("st_ill_req", mif.mem_req, 0);

    // load funct3 011: illegal
    tick();
    drive_req(1'b0, 3'b011, 32'h0000_0060, 32'h0);
    tick();
    req_valid = 1'b0; #1;
    chk("ld011_err", err, 2'b11);
    chk("ld011_req", mif.mem_req, 0);

    // lhu 0x64, never acked: 16 request cycles then timeout
    tick();
    drive_req(1'b0, 3'b101, 32'h0000_0064, 32'h0);
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (mif.mem_req === 1'b1) seen++;
    end
    chk("to_req_cycles", seen, 16);
    tick();
    req_valid = 1'b0; #1;
    chk("to_err", err, 2'b10);
    chk("to_req_off", mif.mem_req, 0);
    chk("to_rvalid", rdata_valid, 0);
    chk("to_rdata_hold", rdata, 32'hFFFF_FF80);

    // same, ack on the 16th WAIT cycle: ack wins
    tick();
    drive_req(1'b0, 3'b101, 32'h0000_0064, 32'h0);
    for (int i = 0; i < 15; i++) tick();
    tick();
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1234_ABCD;
    tick();
    mif.mem_ack = 1'b0; req_valid = 1'b0; #1;
    chk("late_ack_err", err, 0);
    chk("late_ack_rvalid", rdata_valid, 1);
    chk("late_ack_rdata", rdata, 32'h0000_ABCD);

    // sw 0x64, reset during WAIT cycle 2
    tick();
    drive_req(1'b1, 3'b010, 32'h0000_0064, 32'd25);
    tick();
    chk("sw_c1_req", mif.mem_req, 1);
    chk("sw_c1_wdata", mif.mem_wdata, 32'd25);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; req_valid = 1'b0; mif.mem_ack = 1'b1; #1;
    chk("sw_rst_req", mif.mem_req, 0);
    chk("sw_rst_stall", stall, 0);
    chk("sw_rst_rdata", rdata, 0);
    tick();
    mif.mem_ack = 1'b0; #1;
    chk("sw_rst_rvalid", rdata_valid, 0);
    chk("sw_rst_err", err, 0);
    chk("sw_rst_req2", mif.mem_req, 0);

    // back-to-back lw 0x60 then lbu 0x61
    tick();
    drive_req(1'b0, 3'b010, 32'h0000_0060, 32'h0);
    tick();
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1122_3344;
    tick();
    mif.mem_ack = 1'b0;
    drive_req(1'b0, 3'b100, 32'h0000_0061, 32'h0); #1;
    chk("b2b_lw_rdata", rdata, 32'h1122_3344);
    chk("b2b_lw_rvalid", rdata_valid, 1);
    chk("b2b_done_stall", stall, 0);
    tick();
    chk("b2b_accept_stall", stall, 1);
    chk("b2b_accept_req", mif.mem_req, 0);
    tick();
    chk("b2b_lbu_req", mif.mem_req, 1);
    chk("b2b_lbu_be", mif.mem_be, 4'b0010);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1234_F178;
    tick();
    mif.mem_ack = 1'b0; req_valid = 1'b0; #1;
    chk("b2b_lbu_rdata", rdata, 32'h0000_00F1);
    chk("b2b_lbu_rvalid", rdata_valid, 1);

    // lh 0x62: sign-extended upper halfword
    tick();
    drive_req(1'b0, 3'b001, 32'h0000_0062, 32'h0);
    tick();
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h9ABC_0011;
    tick();
    mif.mem_ack = 1'b0; req_valid = 1'b0; #1;
    chk("lh_rdata", rdata, 32'hFFFF_9ABC);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 16, max cycles waited in WAIT for mem_ack before abort (range 2-255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on rising edge of clk.
REQ-004 req_valid  in  1  core presents a data-memory operation.
REQ-005 req_we  in  1  1 = store, 0 = load.
REQ-006 req_funct3  in  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu (stores use 000/001/010).
REQ-007 req_addr  in  32  byte address (core ALU result).
REQ-008 req_wdata  in  32  store data (rs2).
REQ-009 stall  out  1  core holds PC and request while 1.
REQ-010 rdata  out  32  extended load result.
REQ-011 rdata_valid  out  1  one-cycle pulse; rdata valid for a completed load.
REQ-012 err  out  2  completion status: 00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
REQ-013 mem_req, mem_we  out  1 each  memory request strobe / write enable.
REQ-014 mem_addr  out  32  word address, bits [1:0] = 00.
REQ-015 mem_wdata  out  32  lane-replicated store data.
REQ-016 mem_be  out  4  byte enables, bit i = byte lane i (little-endian).
REQ-017 mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
REQ-018 mem_rdata  in  32  memory read word.

Function
REQ-019 FSM states IDLE, WAIT, DONE; stall = (state==IDLE & req_valid) | (state==WAIT).
REQ-020 IDLE & req_valid: capture we, funct3, addr, wdata; legal aligned op -> WAIT; otherwise -> DONE with err set; no memory access for faulted ops.
REQ-021 Alignment: h/hu needs addr[0]=0; w needs addr[1:0]=00; violation -> err 01.
REQ-022 Illegal funct3 (011, 110, 111; any of 1xx on a store) -> err 11; illegal takes priority over misaligned.
REQ-023 WAIT: mem_req=1, mem_we, mem_addr={addr[31:2],2'b00}, mem_wdata, mem_be driven from captured fields, held constant until exit.
REQ-024 Store lanes: b -> wdata[7:0] x4, be = 0001<<addr[1:0]; h -> wdata[15:0] x2, be = 0011 (addr[1]=0) or 1100; w -> be 1111.
REQ-025 Loads drive mem_be per REQ-024 lane rule; mem_wdata don't-care but driven 0.
REQ-026 WAIT & mem_ack -> DONE; load lane selected by captured addr[1:0], sign-extended (b, h) or zero-extended (bu, hu), registered into rdata.
REQ-027 WAIT timeout counter: cleared on WAIT entry, +1 per cycle without ack; at count ACK_TIMEOUT-1 without ack -> DONE, err 10, rdata unchanged.
REQ-028 mem_ack in the same cycle as terminal count: ack wins, err 00.
REQ-029 DONE lasts exactly one cycle: stall=0, rdata_valid=1 only for ok load, err valid; -> IDLE unconditionally.
REQ-030 Latency: accept cycle 0, mem_req from cycle 1, ack cycle k, DONE cycle k+1; zero-wait ack gives 3-cycle op.
REQ-031 mem_ack in IDLE or DONE ignored; no state or output change.
REQ-032 rdata holds last completed load value until the next one; err reads 00 outside DONE.

Reset
REQ-033 reset=1 at a rising edge: state IDLE, counter 0, rdata 0, err 00, rdata_valid 0, mem_req 0, mem_we 0, mem_be 0000, mem_addr 0, mem_wdata 0.
REQ-034 Reset during WAIT aborts: mem_req 0 next cycle, no rdata_valid, late mem_ack ignored.
REQ-035 stall follows REQ-019 combinationally, so stall=1 during reset only if req_valid=1.

Verification
REQ-036 lb addr 0x0000_0063, mem_rdata 0x80FF_1234, ack after 2 cycles -> mem_addr 0x60, be 1000, rdata 0xFFFF_FF80, rdata_valid pulse in cycle 4.
REQ-037 sh addr 0x0000_0066, wdata 0xDEAD_BEEF, zero-wait ack -> mem_wdata 0xBEEF_BEEF, be 1100, mem_we 1, DONE cycle 2, rdata_valid 0.
REQ-038 lw addr 0x0000_0062 -> no mem_req, DONE cycle 1, err 01, stall=0 in cycle 1.
REQ-039 lhu addr 0x64, mem_ack never -> mem_req held 16 cycles, DONE with err 10; repeat with ack on 16th cycle -> err 00.
REQ-040 sw addr 0x64 wdata 25 with reset pulsed in WAIT cycle 2 -> mem_req 0 next cycle, state IDLE, late ack ignored, no rdata_valid.
REQ-041 funct3 011 load -> err 11, no mem_req; back-to-back lw 0x60 then lbu 0x61 -> second accepted in the cycle after first DONE, zero-extended result.
